// File: rtl/ascon_pack.sv
// Shared types and helpers for the Ascon permutation engine: state layout,
// round constants, round counts and the engine FSM encoding.
package ascon_pack;

  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 6;

  // x0 occupies the most significant 64 bits of the flat 320-bit state.
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_RUN  = 1'b1
  } engine_fsm_t;

  // Round constant for index 0..11, added into the low byte of x2.
  function automatic logic [63:0] round_const(input logic [3:0] idx);
    logic [3:0] hi;
    hi = 4'hF - idx;
    return {56'd0, hi, idx};
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/permutation_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box layer
// and linear diffusion layer.
module permutation_round
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] s0, s1, s2, s3, s4;

  always_comb begin
    // Constant addition folded into the S-box input XOR network.
    a0 = state_i.x0 ^ state_i.x4;
    a1 = state_i.x1;
    a2 = state_i.x2 ^ round_const(round_i) ^ state_i.x1;
    a3 = state_i.x3;
    a4 = state_i.x4 ^ state_i.x3;

    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;

    b0 = a0 ^ t1;
    b1 = a1 ^ t2;
    b2 = a2 ^ t3;
    b3 = a3 ^ t4;
    b4 = a4 ^ t0;

    s0 = b0 ^ b4;
    s1 = b1 ^ b0;
    s2 = ~b2;
    s3 = b3 ^ b2;
    s4 = b4;

    state_o.x0 = s0 ^ rotr(s0, 19) ^ rotr(s0, 28);
    state_o.x1 = s1 ^ rotr(s1, 61) ^ rotr(s1, 39);
    state_o.x2 = s2 ^ rotr(s2, 1)  ^ rotr(s2, 6);
    state_o.x3 = s3 ^ rotr(s3, 10) ^ rotr(s3, 17);
    state_o.x4 = s4 ^ rotr(s4, 7)  ^ rotr(s4, 41);
  end

endmodule

// File: rtl/permutation_engine.sv
// Self-sequencing Ascon p^a / p^b engine computing UNROLL rounds per clock.
// Optional begin/end XOR logic is built only when PERMUTATION_XOR_EN is defined.
module permutation_engine
  import ascon_pack::*;
#(
  parameter int UNROLL = 1
) (
  input  logic          clock_i,
  input  logic          resetb_i,
  input  logic          start_i,
  input  logic          mode_i,
  input  type_state     state_i,
  input  logic          xor_begin_i,
  input  logic [63:0]   data_i,
  input  logic          xor_end_i,
  input  logic [127:0]  key_i,
  output type_state     state_o,
  output logic          ready_o,
  output logic          done_o,
  output logic [3:0]    round_o,
  output engine_fsm_t   fsm_state_o
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 3 && UNROLL != 6) begin : g_bad_unroll
    $error("permutation_engine: UNROLL must be 1, 2, 3 or 6");
  end

  // Handshake: start_i is taken on a rising edge only while ready_o is high
  // (including the done cycle); done_o is high for exactly the one cycle in
  // which state_o first carries the finished result.

  engine_fsm_t fsm_q, fsm_d;
  type_state   state_q;
  logic [3:0]  cnt_q;
  logic        done_q;

  logic        accept;
  logic        step;
  logic        last_step;
  logic [3:0]  base_idx;
  type_state   chain_in;
  type_state   chain_out;
  type_state   result;

  assign accept    = (fsm_q == FSM_IDLE) && start_i;
  assign step      = accept || (fsm_q == FSM_RUN);
  assign base_idx  = (fsm_q == FSM_RUN) ? cnt_q :
                     (mode_i ? 4'(ROUNDS_A - ROUNDS_B) : 4'd0);
  assign last_step = (base_idx + 4'(UNROLL)) == 4'(ROUNDS_A);

`ifdef PERMUTATION_XOR_EN
  logic xor_end_q;
  logic xor_end_eff;
  // A start that finishes on its own edge has no latched flag yet.
  assign xor_end_eff = (fsm_q == FSM_IDLE) ? xor_end_i : xor_end_q;
`else
  logic unused_xor_inputs;
  assign unused_xor_inputs = ^{xor_begin_i, data_i, xor_end_i, key_i};
`endif

  always_comb begin
    chain_in = state_q;
    if (fsm_q == FSM_IDLE) begin
      chain_in = state_i;
`ifdef PERMUTATION_XOR_EN
      if (xor_begin_i) chain_in.x0 = state_i.x0 ^ data_i;
`endif
    end
  end

  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    type_state rin;
    type_state rout;
    if (j == 0) begin : g_first
      assign rin = chain_in;
    end else begin : g_next
      assign rin = g_round[j-1].rout;
    end
    permutation_round u_round (
      .state_i (rin),
      .round_i (base_idx + 4'(j)),
      .state_o (rout)
    );
  end

  assign chain_out = g_round[UNROLL-1].rout;

  always_comb begin
    result = chain_out;
`ifdef PERMUTATION_XOR_EN
    if (last_step && xor_end_eff) begin
      result.x3 = chain_out.x3 ^ key_i[127:64];
      result.x4 = chain_out.x4 ^ key_i[63:0];
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) fsm_q <= FSM_IDLE;
    else           fsm_q <= fsm_d;
  end

  // FSM next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      FSM_IDLE: if (accept && !last_step) fsm_d = FSM_RUN;
      FSM_RUN:  if (last_step)            fsm_d = FSM_IDLE;
      default:                            fsm_d = FSM_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready_o     = (fsm_q == FSM_IDLE);
    fsm_state_o = fsm_q;
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q   <= '0;
      cnt_q     <= 4'd0;
      done_q    <= 1'b0;
`ifdef PERMUTATION_XOR_EN
      xor_end_q <= 1'b0;
`endif
    end else begin
      done_q <= step && last_step;
      if (step) begin
        state_q <= result;
        cnt_q   <= base_idx + 4'(UNROLL);
      end
`ifdef PERMUTATION_XOR_EN
      if (accept) xor_end_q <= xor_end_i;
`endif
    end
  end

  assign state_o = state_q;
  assign done_o  = done_q;
  assign round_o = cnt_q;

endmodule

// File: tb/tb_permutation_engine.sv
// Directed bench for permutation_engine: four instances (UNROLL 1/2/3/6) share
// stimulus; results are compared against a table-driven Ascon reference.
module tb_permutation_engine;
  import ascon_pack::*;

  localparam logic [319:0] INIT_STATE = {64'h80400C0600000000,
                                         128'h000102030405060708090A0B0C0D0E0F,
                                         128'h000102030405060708090A0B0C0D0E0F};
  localparam logic [127:0] KEY  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [63:0]  DATA = 64'h0123456789ABCDEF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic         xor_begin = 1'b0;
  logic         xor_end = 1'b0;
  logic [319:0] state_in = '0;
  logic [63:0]  data_in = '0;
  logic [127:0] key_in = '0;

  logic [319:0] st_o [4];
  logic         rdy [4];
  logic         dn [4];
  logic [3:0]   rnd [4];
  engine_fsm_t  fsm_dbg [4];

  int checks = 0;
  int errors = 0;
  logic [319:0] exp_q[$];

  int lat_a [4] = '{12, 6, 4, 2};
  int lat_b [4] = '{6, 3, 2, 1};

  logic [4:0] sbox_tab [32] = '{5'd4, 5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9, 5'd2,
                                5'd27, 5'd5, 5'd8, 5'd18, 5'd29, 5'd3, 5'd6, 5'd28,
                                5'd30, 5'd19, 5'd7, 5'd14, 5'd0, 5'd13, 5'd17, 5'd24,
                                5'd16, 5'd12, 5'd1, 5'd25, 5'd22, 5'd10, 5'd15, 5'd23};

  // Clock
  always #5 clk = ~clk;

  permutation_engine #(.UNROLL(1)) u_dut1 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .mode_i(mode), .state_i(state_in),
    .xor_begin_i(xor_begin), .data_i(data_in), .xor_end_i(xor_end), .key_i(key_in),
    .state_o(st_o[0]), .ready_o(rdy[0]), .done_o(dn[0]), .round_o(rnd[0]), .fsm_state_o(fsm_dbg[0]));
  permutation_engine #(.UNROLL(2)) u_dut2 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .mode_i(mode), .state_i(state_in),
    .xor_begin_i(xor_begin), .data_i(data_in), .xor_end_i(xor_end), .key_i(key_in),
    .state_o(st_o[1]), .ready_o(rdy[1]), .done_o(dn[1]), .round_o(rnd[1]), .fsm_state_o(fsm_dbg[1]));
  permutation_engine #(.UNROLL(3)) u_dut3 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .mode_i(mode), .state_i(state_in),
    .xor_begin_i(xor_begin), .data_i(data_in), .xor_end_i(xor_end), .key_i(key_in),
    .state_o(st_o[2]), .ready_o(rdy[2]), .done_o(dn[2]), .round_o(rnd[2]), .fsm_state_o(fsm_dbg[2]));
  permutation_engine #(.UNROLL(6)) u_dut6 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .mode_i(mode), .state_i(state_in),
    .xor_begin_i(xor_begin), .data_i(data_in), .xor_end_i(xor_end), .key_i(key_in),
    .state_o(st_o[3]), .ready_o(rdy[3]), .done_o(dn[3]), .round_o(rnd[3]), .fsm_state_o(fsm_dbg[3]));

  // Reference model
  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v};
    return d[n +: 64];
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s_in, input int first);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  sv;
    for (int k = 0; k < 5; k++) x[k] = s_in[319 - 64*k -: 64];
    for (int r = first; r < 12; r++) begin
      x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        sv  = sbox_tab[col];
        for (int k = 0; k < 5; k++) y[k][b] = sv[4 - k];
      end
      x[0] = y[0] ^ ror64(y[0], 19) ^ ror64(y[0], 28);
      x[1] = y[1] ^ ror64(y[1], 61) ^ ror64(y[1], 39);
      x[2] = y[2] ^ ror64(y[2], 1)  ^ ror64(y[2], 6);
      x[3] = y[3] ^ ror64(y[3], 10) ^ ror64(y[3], 17);
      x[4] = y[4] ^ ror64(y[4], 7)  ^ ror64(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  // Scoreboard checks
  task automatic check_vec(input string tag, input logic [319:0] obs, input logic [319:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_idle_reset(input string tag, input int d);
    check_vec($sformatf("%s state dut%0d", tag, d), st_o[d], '0);
    check_int($sformatf("%s ready dut%0d", tag, d), int'(rdy[d]), 1);
    check_int($sformatf("%s done dut%0d", tag, d), int'(dn[d]), 0);
    check_int($sformatf("%s round dut%0d", tag, d), int'(rnd[d]), 0);
    check_int($sformatf("%s fsm dut%0d", tag, d), int'(fsm_dbg[d]), int'(FSM_IDLE));
  endtask

  // Drivers
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One operation on all four instances; start is pulsed for one edge.
  task automatic run_op(input string tag, input logic m, input logic xb, input logic xe,
                        input logic [319:0] s, input logic [319:0] expv);
    int         lat [4];
    int         pulses [4];
    logic [319:0] got [4];
    int         rdy_at [4];
    int         rnd_at [4];
    logic [319:0] e;
    for (int d = 0; d < 4; d++) begin
      lat[d] = 0; pulses[d] = 0; got[d] = '0; rdy_at[d] = 0; rnd_at[d] = 0;
    end
    exp_q.push_back(expv);
    mode = m; xor_begin = xb; xor_end = xe; state_in = s; data_in = DATA; key_in = KEY;
    start = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      for (int d = 0; d < 4; d++) begin
        if (dn[d]) begin
          pulses[d]++;
          if (lat[d] == 0) begin
            lat[d] = cyc; got[d] = st_o[d]; rdy_at[d] = int'(rdy[d]); rnd_at[d] = int'(rnd[d]);
          end
        end
      end
    end
    e = exp_q.pop_front();
    for (int d = 0; d < 4; d++) begin
      check_int($sformatf("%s latency dut%0d", tag, d), lat[d], m ? lat_b[d] : lat_a[d]);
      check_vec($sformatf("%s result dut%0d", tag, d), got[d], e);
      check_int($sformatf("%s ready_at_done dut%0d", tag, d), rdy_at[d], 1);
      check_int($sformatf("%s round_at_done dut%0d", tag, d), rnd_at[d], 12);
      check_int($sformatf("%s done_pulses dut%0d", tag, d), pulses[d], 1);
    end
  endtask

  initial begin
    logic [319:0] e_pa, e_pb, e_pb_xb, e_pa_xe, s_xb;
    int d1, d2, np;
    logic [319:0] g1, g2;

    e_pa = model_perm(INIT_STATE, 0);
    e_pb = model_perm(INIT_STATE, 6);
    s_xb = INIT_STATE;
    e_pa_xe = e_pa;
`ifdef PERMUTATION_XOR_EN
    s_xb[319:256] = INIT_STATE[319:256] ^ DATA;
    e_pa_xe[127:64] = e_pa[127:64] ^ KEY[127:64];
    e_pa_xe[63:0]   = e_pa[63:0] ^ KEY[63:0];
`endif
    e_pb_xb = model_perm(s_xb, 6);

    // Reset state held with no start
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      for (int d = 0; d < 4; d++) check_idle_reset("idle_after_reset", d);
      @(negedge clk);
    end

    // p^a, no XORs
    run_op("pa_plain", 1'b0, 1'b0, 1'b0, INIT_STATE, e_pa);

    // p^b with begin-XOR on every unroll factor
    run_op("pb_xor_begin", 1'b1, 1'b1, 1'b0, INIT_STATE, e_pb_xb);

    // p^a with end-XOR
    run_op("pa_xor_end", 1'b0, 1'b0, 1'b1, INIT_STATE, e_pa_xe);

    // start held high: p^a then p^b back to back on UNROLL=1
    mode = 1'b0; xor_begin = 1'b0; xor_end = 1'b0; state_in = INIT_STATE;
    d1 = 0; d2 = 0; np = 0; g1 = '0; g2 = '0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check_int("b2b ready_in_run", int'(rdy[0]), 0);
      if (cyc == 2) check_int("b2b fsm_in_run", int'(fsm_dbg[0]), int'(FSM_RUN));
      if (dn[0]) begin
        np++;
        if (d1 == 0) begin d1 = cyc; g1 = st_o[0]; end
        else if (d2 == 0) begin d2 = cyc; g2 = st_o[0]; end
      end
      if (cyc == 12) mode = 1'b1;
      if (cyc == 18) start = 1'b0;
    end
    check_int("b2b first_done", d1, 12);
    check_int("b2b second_done", d2, 18);
    check_int("b2b pulse_count", np, 2);
    check_vec("b2b first_result", g1, e_pa);
    check_vec("b2b second_result", g2, e_pb);

    // start pulse mid-RUN is ignored
    mode = 1'b0; state_in = INIT_STATE;
    d1 = 0; np = 0; g1 = '0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 5) begin
        check_int("midrun ready_before_pulse", int'(rdy[0]), 0);
        start = 1'b1; mode = 1'b1; state_in = ~INIT_STATE;
      end
      if (cyc == 6) start = 1'b0;
      if (dn[0]) begin
        np++;
        if (d1 == 0) begin d1 = cyc; g1 = st_o[0]; end
      end
    end
    check_int("midrun done_cycle", d1, 12);
    check_int("midrun pulse_count", np, 1);
    check_vec("midrun result", g1, e_pa);

    // Asynchronous reset in the middle of a p^a run
    mode = 1'b0; state_in = INIT_STATE;
    start = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
    end
    check_int("rst_mid round_before", int'(rnd[0]), 5);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) check_idle_reset("rst_mid async", d);
    @(negedge clk);
    rst_n = 1'b1;
    np = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) if (dn[d]) np++;
    end
    check_int("rst_mid no_done_after", np, 0);
    for (int d = 0; d < 4; d++) check_idle_reset("rst_mid quiet", d);
    run_op("pa_after_reset", 1'b0, 1'b0, 1'b0, INIT_STATE, e_pa);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
